// File: rtl/main_text_transform.sv
`default_nettype none
// ============================================================================
// Module   : main_text_transform
// Purpose  : Text frame transform stage between min_os text RX and TX.
//            Captures received frames into a small circular queue, transforms
//            each one byte per clock (pass / upper-case / reverse / ROT13),
//            then offers the result to TX with a valid/ready handshake.
//            Keeps saturating emitted / dropped frame counters.
// Ports    : clk, rst (async, active-high)
//            mode              - transform select, latched at frame load
//            rx_text_bytes/size, rx_is_text_ready (0->1 = new frame)
//            tx_text_bytes/size, tx_text_valid, tx_text_ready
//            busy              - FSM active or frames queued
//            frames_out, frames_dropped - saturating 8-bit counters
// Revision : 1.0 - initial release
// ============================================================================
module main_text_transform #(
  parameter int MAX_BYTES = 32,
  parameter int DEPTH     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [MAX_BYTES*8-1:0] rx_text_bytes,
  input  logic [7:0]             rx_text_size,
  input  logic                   rx_is_text_ready,
  output logic [MAX_BYTES*8-1:0] tx_text_bytes,
  output logic [7:0]             tx_text_size,
  output logic                   tx_text_valid,
  input  logic                   tx_text_ready,
  output logic                   busy,
  output logic [7:0]             frames_out,
  output logic [7:0]             frames_dropped
);

  localparam int            c_W        = MAX_BYTES * 8;
  localparam int            c_PW       = $clog2(DEPTH);
  localparam int            c_IW       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [c_PW:0] c_DEPTH    = (c_PW + 1)'(DEPTH);
  localparam logic [7:0]    c_MAX_SIZE = 8'(MAX_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFORM = 2'd1,
    S_EMIT  = 2'd2
  } t_state;

  t_state r_state;
  t_state w_state_nxt;

  // Capture side
  logic            r_rdy_prev;
  logic            w_edge;
  logic [7:0]      w_eff_size;
  logic            w_full;
  logic            w_nempty;
  logic            w_enq;
  logic            w_drop;
  logic            w_deq;

  // Frame queue
  logic [c_W-1:0]  r_q_bytes [DEPTH];
  logic [7:0]      r_q_size  [DEPTH];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_PW:0]   r_count;

  // Work registers for the frame being transformed
  logic [c_W-1:0]  r_work_bytes;
  logic [7:0]      r_work_size;
  logic [1:0]      r_work_mode;
  logic [c_IW-1:0] r_idx;
  logic [c_IW-1:0] w_src_idx;
  logic [7:0]      w_src_byte;
  logic [7:0]      w_xbyte;
  logic            w_last;

  // Per-byte transform for the non-reordering modes; ROT13 is split into
  // the first and second half of each alphabet so no modulo is needed.
  function automatic logic [7:0] f_xform(input logic [1:0] m, input logic [7:0] b);
    logic [7:0] v;
    v = b;
    case (m)
      2'd1: begin
        if (b >= 8'h61 && b <= 8'h7A) v = b - 8'h20;
      end
      2'd3: begin
        if ((b >= 8'h41 && b <= 8'h4D) || (b >= 8'h61 && b <= 8'h6D))
          v = b + 8'd13;
        else if ((b >= 8'h4E && b <= 8'h5A) || (b >= 8'h6E && b <= 8'h7A))
          v = b - 8'd13;
      end
      default: v = b;
    endcase
    return v;
  endfunction

  assign w_edge     = rx_is_text_ready & ~r_rdy_prev;
  assign w_eff_size = (rx_text_size > c_MAX_SIZE) ? c_MAX_SIZE : rx_text_size;
  // Full is judged on occupancy before this edge's dequeue.
  assign w_full     = (r_count == c_DEPTH);
  assign w_nempty   = (r_count != '0);
  assign w_enq      = w_edge && (w_eff_size != 8'd0) && !w_full;
  assign w_drop     = w_edge && (w_eff_size != 8'd0) && w_full;
  assign w_deq      = (r_state == S_IDLE) && w_nempty;

  // Reverse mode reads from the mirrored position within the valid bytes.
  assign w_src_idx  = (r_work_mode == 2'd2) ? c_IW'(r_work_size - 8'd1 - 8'(r_idx)) : r_idx;
  assign w_src_byte = r_work_bytes[{w_src_idx, 3'b000} +: 8];
  assign w_xbyte    = f_xform(r_work_mode, w_src_byte);
  assign w_last     = (8'(r_idx) == r_work_size - 8'd1);

  assign busy = (r_state != S_IDLE) || w_nempty;

  // Queue storage needs no reset: occupancy governs what is valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_bytes[r_wptr] <= rx_text_bytes;
      r_q_size[r_wptr]  <= w_eff_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_prev <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_rdy_prev <= rx_is_text_ready;
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_nempty)      w_state_nxt = S_XFORM;
      S_XFORM: if (w_last)        w_state_nxt = S_EMIT;
      S_EMIT:  if (tx_text_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work_bytes   <= '0;
      r_work_size    <= 8'd0;
      r_work_mode    <= 2'd0;
      r_idx          <= '0;
      tx_text_bytes  <= '0;
      tx_text_size   <= 8'd0;
      tx_text_valid  <= 1'b0;
      frames_out     <= 8'd0;
      frames_dropped <= 8'd0;
    end else begin
      if (w_drop && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (w_nempty) begin
            r_work_bytes  <= r_q_bytes[r_rptr];
            r_work_size   <= r_q_size[r_rptr];
            r_work_mode   <= mode;
            r_idx         <= '0;
            // Clearing here leaves every byte at or beyond size as zero.
            tx_text_bytes <= '0;
          end
        end
        S_XFORM: begin
          tx_text_bytes[{r_idx, 3'b000} +: 8] <= w_xbyte;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            tx_text_size  <= r_work_size;
            tx_text_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (tx_text_ready) begin
            tx_text_valid <= 1'b0;
            if (frames_out != 8'hFF) frames_out <= frames_out + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_text_transform.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_text_transform
// Purpose  : Self-checking bench for main_text_transform. Random frames are
//            compared against a byte-array reference model of the transforms.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_text_transform;

  localparam int MB = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      mode = 2'd0;
  logic [MB*8-1:0] rx_text_bytes = '0;
  logic [7:0]      rx_text_size = 8'd0;
  logic            rx_is_text_ready = 1'b0;
  logic [MB*8-1:0] tx_text_bytes;
  logic [7:0]      tx_text_size;
  logic            tx_text_valid;
  logic            tx_text_ready = 1'b1;
  logic            busy;
  logic [7:0]      frames_out;
  logic [7:0]      frames_dropped;

  int total = 0;
  int bad   = 0;
  int e_out = 0;
  int e_drop = 0;

  main_text_transform #(.MAX_BYTES(MB), .DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (mode),
    .rx_text_bytes    (rx_text_bytes),
    .rx_text_size     (rx_text_size),
    .rx_is_text_ready (rx_is_text_ready),
    .tx_text_bytes    (tx_text_bytes),
    .tx_text_size     (tx_text_size),
    .tx_text_valid    (tx_text_valid),
    .tx_text_ready    (tx_text_ready),
    .busy             (busy),
    .frames_out       (frames_out),
    .frames_dropped   (frames_dropped)
  );

  always #5 clk = ~clk;

  // Reference model: works on an array of bytes with plain arithmetic.
  function automatic logic [MB*8-1:0] model(input logic [1:0] m, input logic [MB*8-1:0] in, input int sz);
    int b [MB];
    int c;
    logic [MB*8-1:0] o;
    o = '0;
    for (int i = 0; i < MB; i++) b[i] = int'(in[8*i +: 8]);
    for (int i = 0; i < sz; i++) begin
      c = b[i];
      if (m == 2'd1 && b[i] >= 97 && b[i] <= 122) c = b[i] - 32;
      if (m == 2'd2) c = b[sz-1-i];
      if (m == 2'd3) begin
        if (b[i] >= 65 && b[i] <= 90)  c = (b[i] - 65 + 13) % 26 + 65;
        if (b[i] >= 97 && b[i] <= 122) c = (b[i] - 97 + 13) % 26 + 97;
      end
      o[8*i +: 8] = 8'(c);
    end
    return o;
  endfunction

  function automatic logic [MB*8-1:0] s2f(input string s);
    logic [MB*8-1:0] f;
    f = '0;
    for (int i = 0; i < s.len(); i++) f[8*i +: 8] = s[i];
    return f;
  endfunction

  function automatic logic [MB*8-1:0] rand_frame();
    logic [MB*8-1:0] f;
    for (int i = 0; i < MB; i++)
      f[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(65, 122));
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the capture edge (cycle 0).
  task automatic send_edge(input logic [MB*8-1:0] f, input int sz, input logic [1:0] m);
    tick();
    rx_text_bytes    = f;
    rx_text_size     = 8'(sz);
    mode             = m;
    rx_is_text_ready = 1'b1;
    tick();
    rx_is_text_ready = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [1:0] m, input logic [MB*8-1:0] f,
                           input int sz, input bit toggle, input logic [MB*8-1:0] want_const,
                           input bit use_const);
    logic [MB*8-1:0] exp;
    int esz, n;
    bit got;
    esz = (sz > MB) ? MB : sz;
    exp = use_const ? want_const : model(m, f, esz);
    send_edge(f, sz, m);
    n = 0; got = 0;
    while (!got && n < 200) begin
      tick();
      n++;
      if (tx_text_valid) got = 1;
      else if (toggle) mode = 2'($urandom_range(0, 3));
    end
    total++;
    if (!got || n != esz + 1) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, n, esz + 1);
    end
    total++;
    if (tx_text_bytes !== exp) begin
      bad++; $display("FAIL %s bytes: got %h want %h", name, tx_text_bytes, exp);
    end
    total++;
    if (tx_text_size !== 8'(esz)) begin
      bad++; $display("FAIL %s size: got %0d want %0d", name, tx_text_size, esz);
    end
    tick();
    e_out++;
    total++;
    if (tx_text_valid !== 1'b0 || frames_out !== 8'(e_out)) begin
      bad++; $display("FAIL %s after-accept: got valid=%b out=%0d want valid=0 out=%0d",
                      name, tx_text_valid, frames_out, e_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (tx_text_bytes !== '0 || tx_text_size !== 8'd0 || tx_text_valid !== 1'b0 ||
        busy !== 1'b0 || frames_out !== 8'd0 || frames_dropped !== 8'd0) begin
      bad++; $display("FAIL reset: got valid=%b size=%0d busy=%b out=%0d drop=%0d want all 0",
                      tx_text_valid, tx_text_size, busy, frames_out, frames_dropped);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    tx_text_ready = 1'b1;
    run_frame("upper abZ!", 2'd1, s2f("abZ!"), 4, 0, s2f("ABZ!"), 1);
    run_frame("reverse HELLO", 2'd2, s2f("HELLO"), 5, 0, s2f("OLLEH"), 1);
    run_frame("rot13 Nz", 2'd3, s2f("Nz"), 2, 0, s2f("Am"), 1);
    begin
      logic [MB*8-1:0] f;
      f = rand_frame();
      run_frame("clamp 40", 2'd0, f, 40, 0, f, 1);
    end
  endtask

  task automatic test_random_modes();
    for (int k = 0; k < 12; k++)
      run_frame("random", 2'($urandom_range(0, 3)), rand_frame(), $urandom_range(1, 36), 0, '0, 0);
  endtask

  task automatic test_mode_toggle();
    run_frame("mode toggle abc", 2'd1, s2f("abc"), 3, 1, s2f("ABC"), 1);
  endtask

  task automatic test_backpressure();
    logic [MB*8-1:0] fr [4];
    int sz [4];
    logic [1:0] bm;
    int j, n;
    bm = 2'($urandom_range(0, 3));
    tx_text_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fr[k] = rand_frame();
      sz[k] = $urandom_range(1, 8);
      send_edge(fr[k], sz[k], bm);
    end
    repeat (20) tick();
    e_drop++;
    total++;
    if (frames_dropped !== 8'(e_drop)) begin
      bad++; $display("FAIL backpressure drop: got %0d want %0d", frames_dropped, e_drop);
    end
    total++;
    if (tx_text_valid !== 1'b1 || busy !== 1'b1 || tx_text_bytes !== model(bm, fr[0], sz[0])) begin
      bad++; $display("FAIL backpressure hold: got valid=%b busy=%b bytes=%h want 1 1 %h",
                      tx_text_valid, busy, tx_text_bytes, model(bm, fr[0], sz[0]));
    end
    tx_text_ready = 1'b1;
    j = 1; n = 0;
    while (j < 3 && n < 200) begin
      tick();
      n++;
      if (tx_text_valid) begin
        total++;
        if (tx_text_bytes !== model(bm, fr[j], sz[j]) || tx_text_size !== 8'(sz[j])) begin
          bad++; $display("FAIL backpressure frame %0d: got %h/%0d want %h/%0d", j,
                          tx_text_bytes, tx_text_size, model(bm, fr[j], sz[j]), sz[j]);
        end
        j++;
      end
    end
    tick();
    e_out += 3;
    total++;
    if (j != 3 || frames_out !== 8'(e_out)) begin
      bad++; $display("FAIL backpressure drain: got frames=%0d out=%0d want 3 out=%0d", j, frames_out, e_out);
    end
  endtask

  task automatic test_held_level();
    int cnt;
    cnt = 0;
    tick();
    rx_text_bytes    = rand_frame();
    rx_text_size     = 8'd3;
    mode             = 2'($urandom_range(0, 3));
    rx_is_text_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_text_valid) cnt++;
    end
    rx_is_text_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_text_valid) cnt++;
    end
    e_out++;
    total++;
    if (cnt != 1 || frames_out !== 8'(e_out)) begin
      bad++; $display("FAIL held level: got pulses=%0d out=%0d want 1 out=%0d", cnt, frames_out, e_out);
    end
  endtask

  task automatic test_size_zero();
    int cnt;
    cnt = 0;
    send_edge(rand_frame(), 0, 2'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx_text_valid) cnt++;
    end
    total++;
    if (cnt != 0 || frames_out !== 8'(e_out) || frames_dropped !== 8'(e_drop) || busy !== 1'b0) begin
      bad++; $display("FAIL size zero: got pulses=%0d out=%0d drop=%0d busy=%b want 0 %0d %0d 0",
                      cnt, frames_out, frames_dropped, busy, e_out, e_drop);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    tx_text_ready = 1'b1;
    send_edge(rand_frame(), 20, 2'd0);
    send_edge(rand_frame(), 5, 2'd0);
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset mid pre-busy: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (tx_text_bytes !== '0 || tx_text_size !== 8'd0 || tx_text_valid !== 1'b0 ||
        busy !== 1'b0 || frames_out !== 8'd0 || frames_dropped !== 8'd0) begin
      bad++; $display("FAIL reset mid: got valid=%b size=%0d busy=%b out=%0d drop=%0d want all 0",
                      tx_text_valid, tx_text_size, busy, frames_out, frames_dropped);
    end
    e_out = 0;
    e_drop = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_text_valid) cnt++;
    end
    total++;
    if (cnt != 0 || busy !== 1'b0 || frames_out !== 8'd0) begin
      bad++; $display("FAIL reset mid stale: got pulses=%0d busy=%b out=%0d want 0 0 0", cnt, busy, frames_out);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_modes();
    test_mode_toggle();
    test_backpressure();
    test_held_level();
    test_size_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
